// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM states,
// parity mode encodings and the default bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // 50 MHz system clock / 115200 baud
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

    // Even mode sends the XOR of the data bits, odd mode its complement.
    // Narrower words are zero-extended, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [8:0] data, input int unsigned mode);
        return (mode == PARITY_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART transmitter;
// dout_o is valid whenever empty_o is low.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: FIFO-buffered words are sent LSB first with
// optional parity and 1 or 2 stop bits, frames back-to-back with no idle gap.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          CLOCK,
    input  logic                          RESET,
    input  logic                          TX_DATA_VALID,
    input  logic [DATA_BITS-1:0]          TX_BYTE,
    output logic                          O_TX_READY,
    output logic                          O_TX_SERIAL,
    output logic                          O_TX_BUSY,
    output logic                          O_TX_DONE,
    output logic [$clog2(FIFO_DEPTH):0]   O_FIFO_COUNT
);

    localparam int unsigned BW = $clog2(CLKS_PER_BIT);
    localparam int unsigned IW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
    localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be 5..9");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
        end
        if (CLKS_PER_BIT < 2) begin : g_bad_cpb
            $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
        end
        if (PARITY_MODE > PARITY_EVEN) begin : g_bad_parity
            $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
        end
    endgenerate

    tx_state_e             state_q;
    logic [BW-1:0]         baud_q;
    logic [IW-1:0]         bit_q;
    logic                  stop_q;
    logic [DATA_BITS-1:0]  shift_q;
    logic                  par_q;
    logic                  serial_q;
    logic                  busy_q;
    logic                  done_q;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_BITS-1:0]  fifo_dout;
    logic                  baud_end;
    logic                  stop_end;

    assign O_TX_READY = !fifo_full;
    assign fifo_push  = TX_DATA_VALID && O_TX_READY;
    assign baud_end   = (baud_q == BAUD_LAST);
    assign stop_end   = (state_q == STOP) && baud_end && (stop_q == STOP_LAST);
    assign fifo_pop   = !fifo_empty && ((state_q == IDLE) || stop_end);

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLOCK),
        .rst_i   (RESET),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (TX_BYTE),
        .dout_o  (fifo_dout),
        .count_o (O_FIFO_COUNT),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // The shift register moves right once per data bit, so shift_q[0] is
    // always the bit on the line; parity is captured when the word is popped.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            baud_q <= baud_end ? '0 : baud_q + 1'b1;
            unique case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    if (fifo_pop) begin
                        shift_q  <= fifo_dout;
                        par_q    <= parity_bit(9'(fifo_dout), PARITY_MODE);
                        bit_q    <= '0;
                        stop_q   <= 1'b0;
                        serial_q <= 1'b0;
                        busy_q   <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        serial_q <= shift_q[0];
                        state_q  <= DATA;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        if (bit_q == BIT_LAST) begin
                            if (PARITY_MODE != PARITY_NONE) begin
                                serial_q <= par_q;
                                state_q  <= PARITY;
                            end else begin
                                serial_q <= 1'b1;
                                stop_q   <= 1'b0;
                                state_q  <= STOP;
                            end
                        end else begin
                            serial_q <= shift_q[1];
                            shift_q  <= shift_q >> 1;
                            bit_q    <= bit_q + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (baud_end) begin
                        serial_q <= 1'b1;
                        stop_q   <= 1'b0;
                        state_q  <= STOP;
                    end
                end
                STOP: begin
                    // Raise done one cycle early so the registered pulse
                    // lines up with the final stop cycle.
                    if (baud_q == BAUD_PRE && stop_q == STOP_LAST) begin
                        done_q <= 1'b1;
                    end
                    if (baud_end) begin
                        if (stop_q != STOP_LAST) begin
                            stop_q <= 1'b1;
                        end else if (fifo_pop) begin
                            shift_q  <= fifo_dout;
                            par_q    <= parity_bit(9'(fifo_dout), PARITY_MODE);
                            bit_q    <= '0;
                            stop_q   <= 1'b0;
                            serial_q <= 1'b0;
                            state_q  <= START;
                        end else begin
                            serial_q <= 1'b1;
                            busy_q   <= 1'b0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    assign O_TX_SERIAL = serial_q;
    assign O_TX_BUSY   = busy_q;
    assign O_TX_DONE   = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: three frame formats, each checked cycle by cycle
// against a queue-of-line-levels reference model.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       v;
    logic [8:0] w;
    int         sel;

    logic [2:0] ready, serial, busy, done;
    logic [2:0] cnt0, cnt1;
    logic [1:0] cnt2;
    logic       cur_ready, cur_serial, cur_busy, cur_done;
    logic [3:0] cur_cnt;

    always #5 clk = ~clk;

    // 8N1, CLKS_PER_BIT=4, depth 4
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
        .CLOCK(clk), .RESET(rst), .TX_DATA_VALID(v && (sel == 0)), .TX_BYTE(w[7:0]),
        .O_TX_READY(ready[0]), .O_TX_SERIAL(serial[0]), .O_TX_BUSY(busy[0]),
        .O_TX_DONE(done[0]), .O_FIFO_COUNT(cnt0));

    // 7 data bits, even parity, 2 stop bits
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
        .CLOCK(clk), .RESET(rst), .TX_DATA_VALID(v && (sel == 1)), .TX_BYTE(w[6:0]),
        .O_TX_READY(ready[1]), .O_TX_SERIAL(serial[1]), .O_TX_BUSY(busy[1]),
        .O_TX_DONE(done[1]), .O_FIFO_COUNT(cnt1));

    // 9 data bits, odd parity, minimum bit period, depth 2
    uart_tx_param #(.CLKS_PER_BIT(2), .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u_c (
        .CLOCK(clk), .RESET(rst), .TX_DATA_VALID(v && (sel == 2)), .TX_BYTE(w),
        .O_TX_READY(ready[2]), .O_TX_SERIAL(serial[2]), .O_TX_BUSY(busy[2]),
        .O_TX_DONE(done[2]), .O_FIFO_COUNT(cnt2));

    always_comb begin
        cur_ready  = ready[0];
        cur_serial = serial[0];
        cur_busy   = busy[0];
        cur_done   = done[0];
        cur_cnt    = {1'b0, cnt0};
        case (sel)
            1: begin
                cur_ready = ready[1]; cur_serial = serial[1]; cur_busy = busy[1];
                cur_done  = done[1];  cur_cnt    = {1'b0, cnt1};
            end
            2: begin
                cur_ready = ready[2]; cur_serial = serial[2]; cur_busy = busy[2];
                cur_done  = done[2];  cur_cnt    = {2'b00, cnt2};
            end
            default: ;
        endcase
    end

    function automatic int cpb(input int k); return (k == 2) ? 2 : 4; endfunction
    function automatic int db(input int k);  return (k == 0) ? 8 : (k == 1) ? 7 : 9; endfunction
    function automatic int pm(input int k);  return (k == 0) ? 0 : (k == 1) ? 2 : 1; endfunction
    function automatic int sb(input int k);  return (k == 1) ? 2 : 1; endfunction
    function automatic int dep(input int k); return (k == 2) ? 2 : 4; endfunction

    // Reference model: mq holds accepted-but-unsent words, lq the remaining
    // line levels (one entry per clock) of the frame in flight.
    logic [8:0] mq[$];
    bit         lq[$];
    logic [8:0] stim[$];
    logic       e_line = 1'b1, e_busy = 1'b0, e_done = 1'b0;
    int         fpos = 0;
    int         ncmp = 0, nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_level(input bit b);
        for (int i = 0; i < cpb(sel); i++) lq.push_back(b);
    endtask

    task automatic model_edge(output bit acc);
        int         sz;
        logic [8:0] wd;
        logic [8:0] mask;
        sz   = mq.size();
        acc  = 1'b0;
        mask = 9'((1 << db(sel)) - 1);
        if (rst) begin
            mq.delete(); lq.delete();
            e_line = 1'b1; e_busy = 1'b0; e_done = 1'b0; fpos = 0;
            return;
        end
        acc = v && (sz < dep(sel));
        if (lq.size() == 0 && sz > 0) begin
            wd = mq.pop_front();
            push_level(1'b0);
            for (int i = 0; i < db(sel); i++) push_level(wd[i]);
            if (pm(sel) == 2) push_level(^wd);
            if (pm(sel) == 1) push_level(~^wd);
            for (int s = 0; s < sb(sel); s++) push_level(1'b1);
            fpos = 0;
        end
        if (lq.size() > 0) begin
            e_line = lq.pop_front();
            e_busy = 1'b1;
            e_done = (lq.size() == 0);
            fpos++;
        end else begin
            e_line = 1'b1; e_busy = 1'b0; e_done = 1'b0;
        end
        if (acc) mq.push_back(w & mask);
    endtask

    task automatic step(output bit acc);
        model_edge(acc);
        @(posedge clk);
        @(negedge clk);
        chk("serial", cur_serial, e_line);
        chk("busy",   cur_busy,   e_busy);
        chk("done",   cur_done,   e_done);
        chk("count",  cur_cnt,    mq.size());
        chk("ready",  cur_ready,  mq.size() < dep(sel));
    endtask

    // Offers stim words (valid held high unless rnd) until the model drains,
    // or until the in-flight frame reaches stop_fpos cycles.
    task automatic run(input int k, input bit rnd, input int maxc, input int stop_fpos,
                       output int full_at, output int dones);
        int c = 0;
        int accepted = 0;
        bit acc;
        sel = k;
        full_at = -1;
        dones = 0;
        #1;
        while (c < maxc && (stim.size() > 0 || mq.size() > 0 || lq.size() > 0 || e_busy)) begin
            if (full_at < 0 && !cur_ready) full_at = accepted;
            if (stim.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                v = 1'b1; w = stim[0];
            end else begin
                v = 1'b0; w = 9'($urandom);
            end
            step(acc);
            if (acc) begin
                void'(stim.pop_front());
                accepted++;
            end
            if (cur_done) dones++;
            c++;
            if (stop_fpos > 0 && e_busy && fpos >= stop_fpos) break;
        end
        v = 1'b0;
        chk("within_cycle_budget", c < maxc, 1);
    endtask

    initial begin
        bit acc;
        int full_at, dones;
        rst = 1'b1; v = 1'b0; w = '0; sel = 0;
        @(negedge clk);
        step(acc);
        step(acc);
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #1;
            chk("reset_serial", cur_serial, 1);
            chk("reset_busy",   cur_busy,   0);
            chk("reset_done",   cur_done,   0);
            chk("reset_count",  cur_cnt,    0);
            chk("reset_ready",  cur_ready,  1);
        end
        rst = 1'b0;
        sel = 0;

        // single 8N1 frame of 0x55
        stim = '{9'h055};
        run(0, 1'b0, 100, 0, full_at, dones);
        chk("single_done_pulses", dones, 1);

        // backpressure, back-to-back frames, push refused at full on the pop edge
        stim = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h0A5};
        run(0, 1'b0, 400, 0, full_at, dones);
        chk("accepts_before_not_ready", full_at, 5);
        chk("burst_done_pulses", dones, 6);

        // random words with random valid gaps
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(9'($urandom));
        run(0, 1'b1, 1500, 0, full_at, dones);
        chk("random_done_pulses", dones, 12);

        // even parity of 0x07, all-ones word into two stop bits, then random
        stim = '{9'h007, 9'h07F};
        for (int i = 0; i < 8; i++) stim.push_back(9'($urandom));
        run(1, 1'b1, 1500, 0, full_at, dones);
        chk("parity_even_done_pulses", dones, 10);

        // odd parity of 0x07 and 9-bit words at the minimum bit period
        stim = '{9'h007, 9'h1FF, 9'h100};
        for (int i = 0; i < 8; i++) stim.push_back(9'($urandom));
        run(2, 1'b0, 800, 0, full_at, dones);
        chk("parity_odd_done_pulses", dones, 11);

        // reset during data bit 3 of 0x00 with two words still queued
        stim = '{9'h000, 9'h011, 9'h022};
        run(0, 1'b0, 100, 4 * cpb(0) + 2, full_at, dones);
        chk("queued_before_reset", cur_cnt, 2);
        stim.delete();
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        chk("mid_reset_serial", cur_serial, 1);
        chk("mid_reset_count",  cur_cnt,    0);
        chk("mid_reset_busy",   cur_busy,   0);
        chk("mid_reset_ready",  cur_ready,  1);
        chk("mid_reset_done",   cur_done,   0);
        dones = 0;
        repeat (60) begin
            v = 1'b0;
            w = 9'($urandom);
            step(acc);
            if (cur_done) dones++;
        end
        chk("no_frame_after_reset", dones, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an input FIFO. Data words are accepted on a valid/ready handshake, buffered, and serialised LSB-first on a single line. Frame format is set at elaboration: data width, parity and stop-bit count. Bit period is exact, and frames are sent back-to-back with no idle gap. It sits between the bot's command/telemetry logic and the UART pin, and replaces the fixed 8N1 transmitter.

## Interface
- CLKS_PER_BIT, 434 — clock cycles per serial bit; 50 MHz / 115200; legal range ≥ 2
- DATA_BITS, 8 — data bits per frame; legal 5..9
- PARITY_MODE, 0 — 0 none, 1 odd, 2 even
- STOP_BITS, 1 — legal 1 or 2
- FIFO_DEPTH, 4 — input buffer entries; power of two, ≥ 2
- CLOCK  in  1  — system clock; all logic on the rising edge
- RESET  in  1  — synchronous, active-high reset
- TX_DATA_VALID  in  1  — word offered on TX_BYTE
- TX_BYTE  in  DATA_BITS  — word to transmit
- O_TX_READY  out  1  — FIFO can accept a word; reset value 1
- O_TX_SERIAL  out  1  — serial line, idle high; reset value 1
- O_TX_BUSY  out  1  — a frame is in progress; reset value 0
- O_TX_DONE  out  1  — one-cycle pulse at the end of each frame; reset value 0
- O_FIFO_COUNT  out  $clog2(FIFO_DEPTH)+1  — occupied FIFO entries; reset value 0

## Operation
- Accept: a word is written on a rising edge where TX_DATA_VALID and O_TX_READY are both 1.
  - O_TX_READY = (count < FIFO_DEPTH), decoded from the registered count.
  - Valid while not ready is ignored; the word is not stored and no error is flagged.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - Line is 1 and O_TX_BUSY is 0.
  - If the FIFO is non-empty: pop the head into the shift register, zero the counters, go to START.
- START: line 0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA:
  - Line = shift[bit_idx], LSB first; each bit is held CLKS_PER_BIT cycles.
  - After bit DATA_BITS-1: go to PARITY if PARITY_MODE ≠ 0, otherwise go to STOP.
- PARITY:
  - Even mode: line = XOR of the data bits.
  - Odd mode: line = XNOR of the data bits.
  - Held CLKS_PER_BIT cycles, then go to STOP.
- STOP:
  - Line 1 for STOP_BITS × CLKS_PER_BIT cycles.
  - On the last cycle, pulse O_TX_DONE.
  - If the FIFO is non-empty: pop and go directly to START (no idle cycle). Otherwise go to IDLE.
- Counters:
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps at the terminal count; width $clog2(CLKS_PER_BIT).
  - bit_idx width is $clog2(DATA_BITS).
  - Stop-bit counter is 1 bit.
- Push and pop on the same edge: count is unchanged and both operations take effect.
  - When full, the pop frees a slot and O_TX_READY rises on the next cycle; a push is never accepted while full.
- Reset mid-frame, on the edge where RESET is seen:
  - FIFO is flushed and the FSM returns to IDLE.
  - O_TX_SERIAL = 1, O_TX_DONE = 0, and no partial frame resumes.
- TX_BYTE is sampled only at push; later changes do not affect queued or in-flight words.

## Timing
- Frame length is exactly (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Latency, with the FIFO empty and the FSM in IDLE:
  - Push accepted at edge N; count = 1 after N.
  - Pop at edge N+1; O_TX_SERIAL is 0 from N+1.
- O_TX_BUSY is 1 from the pop edge until the edge after the final stop cycle. It stays 1 across back-to-back frames.
- O_TX_DONE is high for the single cycle that is the last cycle of the stop period.
- All outputs are registered except O_TX_READY, which is decoded from the registered count.

## Structure
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the PARITY_NONE/ODD/EVEN constants (0/1/2);
  - the default CLKS_PER_BIT constant (434).
- One sub-module, uart_tx_fifo:
  - synchronous FIFO, parameters WIDTH and DEPTH;
  - ports push/pop/din/dout/count/full/empty;
  - first-word-fall-through, so dout is valid whenever not empty.
- Elaboration-time checks: DATA_BITS in 5..9, STOP_BITS in 1..2, FIFO_DEPTH a power of two, CLKS_PER_BIT ≥ 2.

## Test plan
- Single 8N1 frame: CLKS_PER_BIT=4, push 0x55 → line reads 0,1,0,1,0,1,0,1,0,1 in 4-cycle bits; O_TX_DONE pulses at cycle 40 after the pop; O_TX_BUSY falls the cycle after.
- Parity: DATA_BITS=7, PARITY_MODE=2, push 0x07 → parity bit 1. With PARITY_MODE=1, the same word gives parity bit 0. Frame length is 10 bits.
- Backpressure and back-to-back frames: FIFO_DEPTH=4, TX_DATA_VALID held high with 0xA0..0xA5.
  - O_TX_READY drops after 5 accepts (1 popped, 4 queued).
  - All 6 words appear in order with no idle cycle between frames.
  - O_TX_DONE pulses 6 times.
- Two stop bits: STOP_BITS=2, CLKS_PER_BIT=4, push 0xFF → line high for 8 cycles after bit 7; total frame 44 cycles.
- Reset mid-frame: assert RESET during bit 3 of 0x00 with 2 words queued.
  - Next edge: O_TX_SERIAL=1, O_FIFO_COUNT=0, O_TX_BUSY=0, O_TX_READY=1.
  - No further frame is sent.
- Push/pop same edge at full: FIFO full, push offered at the stop-bit end edge → push is refused and the pop occurs; O_TX_READY rises the next cycle and the next push is accepted, leaving count = FIFO_DEPTH.
